// File: rtl/usr_seq_ctrl.sv
// Command sequencer for the universal shift register.
// Drives ctrl/d cycle by cycle and reports completion with a done pulse.
module usr_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             ser_in,
  output logic [1:0]       usr_ctrl,
  output logic [WIDTH-1:0] usr_d,
  input  logic [WIDTH-1:0] usr_q,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHL  = 2'b01;
  localparam logic [1:0] OP_SHR  = 2'b10;
  localparam logic [1:0] OP_ROT  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] count_q;
  logic             accept;

  assign accept = cmd_valid && cmd_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= OP_LOAD;
      data_q  <= '0;
      count_q <= '0;
    end else if (accept) begin
      op_q    <= cmd_op;
      data_q  <= cmd_data;
      count_q <= cmd_count;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cmd_op == OP_LOAD || cmd_op == OP_ROT) begin
            state_nx = LOAD;
          end else if (cmd_count != '0) begin
            state_nx = SHIFT;
            cnt_nx   = cmd_count;
          end else begin
            state_nx = DONE;
          end
        end
      end
      LOAD: begin
        if (op_q == OP_ROT && count_q != '0) begin
          state_nx = SHIFT;
          cnt_nx   = count_q;
        end else begin
          state_nx = DONE;
        end
      end
      SHIFT: begin
        cnt_nx = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decode registered state; ser_in/usr_q feed usr_d in SHIFT only
  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state != IDLE);
    done      = (state == DONE);
    result    = '0;
    usr_ctrl  = 2'b00;
    usr_d     = '0;
    case (state)
      LOAD: begin
        usr_ctrl = 2'b11;
        usr_d    = data_q;
      end
      SHIFT: begin
        case (op_q)
          OP_SHL: begin
            usr_ctrl = 2'b01;
            usr_d[0] = ser_in;
          end
          OP_SHR: begin
            usr_ctrl       = 2'b10;
            usr_d[WIDTH-1] = ser_in;
          end
          default: begin
            usr_ctrl = 2'b01;
            usr_d[0] = usr_q[WIDTH-1];
          end
        endcase
      end
      DONE:    result = usr_q;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_usr_seq_ctrl.sv
// Bench for usr_seq_ctrl with a behavioural shift register attached.
// Directed table, backpressure, reset abort and random commands.
module tb_usr_seq_ctrl;
  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [W-1:0]  cmd_data = '0;
  logic [CW-1:0] cmd_count = '0;
  logic          ser_in = 1'b0;
  logic [1:0]    usr_ctrl;
  logic [W-1:0]  usr_d;
  logic [W-1:0]  usr_q;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] mq = '0;

  usr_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count),
    .ser_in(ser_in), .usr_ctrl(usr_ctrl), .usr_d(usr_d),
    .usr_q(usr_q), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // universal shift register being sequenced
  always_ff @(posedge clk or posedge reset) begin
    if (reset) usr_q <= '0;
    else begin
      case (usr_ctrl)
        2'b01:   usr_q <= {usr_q[W-2:0], usr_d[0]};
        2'b10:   usr_q <= {usr_d[W-1], usr_q[W-1:1]};
        2'b11:   usr_q <= usr_d;
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] data,
                         input logic [CW-1:0] cnt, input bit rnd_ser,
                         input bit ser_fix, input bit hold,
                         output int lat, output logic [W-1:0] res);
    int n;
    logic [1:0] ectl[$];
    logic [W-1:0] ed;
    bit sb;
    bit last;
    n = 0;
    lat = 0;
    res = '0;
    while (!cmd_ready && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) begin
      chk("ready_timeout", {31'd0, cmd_ready}, 1);
      return;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_count = cnt;
    @(posedge clk); #1;
    if (hold) begin
      cmd_op    = 2'b00;
      cmd_data  = 8'h5A;
      cmd_count = 4'd7;
    end else begin
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom);
      cmd_data  = W'($urandom);
      cmd_count = CW'($urandom);
    end
    // expected register actions, one per busy cycle
    if (op == 2'b00 || op == 2'b11) ectl.push_back(2'b11);
    if (op != 2'b00) repeat (cnt) ectl.push_back(op == 2'b11 ? 2'b01 : op);
    ectl.push_back(2'b00);
    foreach (ectl[k]) begin
      sb = rnd_ser ? 1'($urandom) : ser_fix;
      ser_in = sb;
      #1;
      case (ectl[k])
        2'b11:   ed = data;
        2'b01:   ed = (op == 2'b11) ? W'(mq[W-1]) : W'(sb);
        2'b10:   ed = {sb, {(W-1){1'b0}}};
        default: ed = '0;
      endcase
      last = (k == ectl.size() - 1);
      chk("usr_ctrl", {30'd0, usr_ctrl}, {30'd0, ectl[k]});
      chk("usr_d", {24'd0, usr_d}, {24'd0, ed});
      chk("busy", {31'd0, busy}, 1);
      chk("cmd_ready_busy", {31'd0, cmd_ready}, 0);
      chk("done", {31'd0, done}, {31'd0, last});
      chk("result", {24'd0, result}, last ? {24'd0, mq} : 32'd0);
      if (done && lat == 0) begin
        lat = k + 1;
        res = result;
      end
      case (ectl[k])
        2'b11:   mq = ed;
        2'b01:   mq = {mq[W-2:0], ed[0]};
        2'b10:   mq = {ed[W-1], mq[W-1:1]};
        default: ;
      endcase
      @(posedge clk); #1;
    end
    chk("idle_ready", {31'd0, cmd_ready}, 1);
    chk("idle_busy", {31'd0, busy}, 0);
    chk("reg_q", {24'd0, usr_q}, {24'd0, mq});
  endtask

  typedef struct {
    logic [1:0]    op;
    logic [W-1:0]  data;
    logic [CW-1:0] cnt;
    bit            ser;
    logic [W-1:0]  exp_res;
    int            exp_lat;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int lat;
    logic [W-1:0] res;
    tbl[0] = '{2'b00, 8'hA5, 4'd0, 1'b0, 8'hA5, 2};
    tbl[1] = '{2'b01, 8'h00, 4'd3, 1'b1, 8'h2F, 4};
    tbl[2] = '{2'b10, 8'hFF, 4'd2, 1'b0, 8'h0B, 3};
    tbl[3] = '{2'b11, 8'h81, 4'd1, 1'b0, 8'h03, 3};
    tbl[4] = '{2'b11, 8'h81, 4'd8, 1'b1, 8'h81, 10};
    tbl[5] = '{2'b01, 8'h77, 4'd0, 1'b1, 8'h81, 1};
    tbl[6] = '{2'b10, 8'h00, 4'd15, 1'b1, 8'hFF, 16};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, cmd_ready}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_result", {24'd0, result}, 0);
    chk("rst_ctrl", {30'd0, usr_ctrl}, 0);
    chk("rst_d", {24'd0, usr_d}, 0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_cmd(tbl[i].op, tbl[i].data, tbl[i].cnt, 1'b0, tbl[i].ser,
              1'b0, lat, res);
      chk("tbl_result", {24'd0, res}, {24'd0, tbl[i].exp_res});
      chk("tbl_latency", lat, tbl[i].exp_lat);
    end

    // different command held valid during a count-5 shift
    run_cmd(2'b01, 8'h00, 4'd5, 1'b1, 1'b0, 1'b1, lat, res);
    chk("bp_latency", lat, 6);
    run_cmd(2'b00, 8'hC3, 4'd0, 1'b1, 1'b0, 1'b0, lat, res);
    chk("bp_result", {24'd0, res}, 32'hC3);

    // reset in the second SHIFT cycle
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_data  = 8'h00;
    cmd_count = 4'd5;
    ser_in    = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_abort_ctrl", {30'd0, usr_ctrl}, 1);
    reset = 1'b1;
    #1;
    chk("abort_ready", {31'd0, cmd_ready}, 1);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_ctrl", {30'd0, usr_ctrl}, 0);
    chk("abort_d", {24'd0, usr_d}, 0);
    chk("abort_q", {24'd0, usr_q}, 0);
    chk("abort_done", {31'd0, done}, 0);
    mq = '0;
    #2 reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", {31'd0, done}, 0);
      chk("abort_idle", {31'd0, busy}, 0);
    end
    run_cmd(2'b00, 8'h3C, 4'd0, 1'b1, 1'b0, 1'b0, lat, res);
    chk("post_abort_result", {24'd0, res}, 32'h3C);
    chk("post_abort_latency", lat, 2);

    for (int i = 0; i < 40; i++) begin
      run_cmd(2'($urandom), W'($urandom), CW'($urandom_range(0, 15)),
              1'b1, 1'b0, 1'b0, lat, res);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
